// File: rtl/procyon_lsu_lq_ctrl.sv
// Load queue controller: free-entry allocation, occupancy tracking, round-robin
// replay arbitration into a registered output stage, and retire-response reduction.
`ifndef PCYN_OP_WIDTH
`define PCYN_OP_WIDTH 5
`endif

module procyon_lsu_lq_ctrl #(
    parameter int OPTN_ADDR_WIDTH    = 32,
    parameter int OPTN_ROB_IDX_WIDTH = 5,
    parameter int OPTN_LQ_DEPTH      = 8,
    parameter int LQ_IDX_WIDTH       = $clog2(OPTN_LQ_DEPTH)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         i_flush,
    input  logic [OPTN_LQ_DEPTH-1:0]                     i_entry_empty,
    input  logic [OPTN_LQ_DEPTH-1:0]                     i_entry_replayable,
    input  logic [OPTN_LQ_DEPTH*`PCYN_OP_WIDTH-1:0]      i_entry_replay_op,
    input  logic [OPTN_LQ_DEPTH*OPTN_ROB_IDX_WIDTH-1:0]  i_entry_replay_tag,
    input  logic [OPTN_LQ_DEPTH*OPTN_ADDR_WIDTH-1:0]     i_entry_replay_addr,
    input  logic                                         i_alloc_req,
    output logic [OPTN_LQ_DEPTH-1:0]                     o_alloc_en,
    output logic                                         o_full,
    output logic [OPTN_LQ_DEPTH-1:0]                     o_entry_replay_en,
    output logic                                         o_replay_valid,
    output logic [`PCYN_OP_WIDTH-1:0]                    o_replay_op,
    output logic [OPTN_ROB_IDX_WIDTH-1:0]                o_replay_tag,
    output logic [OPTN_ADDR_WIDTH-1:0]                   o_replay_addr,
    input  logic                                         i_replay_ack,
    input  logic [OPTN_LQ_DEPTH-1:0]                     i_entry_retire_ack,
    input  logic [OPTN_LQ_DEPTH-1:0]                     i_entry_retire_misspec,
    output logic                                         o_rob_retire_ack,
    output logic                                         o_rob_retire_misspeculated
);

    localparam int OPW = `PCYN_OP_WIDTH;
    localparam int CW  = LQ_IDX_WIDTH + 1;

    // Handshake: the output stage is offered while o_replay_valid is high and is
    // consumed in any cycle where i_replay_ack is high; the stage may reload that same cycle.

    logic [CW-1:0]           count;
    logic [CW-1:0]           count_next;
    logic [LQ_IDX_WIDTH-1:0] rr_ptr;
    logic                    alloc_fire;
    logic                    alloc_found;
    logic                    stage_load;
    logic                    replay_fire;
    logic                    replay_found;
    logic [LQ_IDX_WIDTH-1:0] winner;
    logic [LQ_IDX_WIDTH-1:0] probe;

    assign alloc_fire  = i_alloc_req & ~o_full & ~i_flush & ~rst;
    assign stage_load  = ~o_replay_valid | i_replay_ack;
    assign replay_fire = stage_load & ~i_flush & ~rst & (|i_entry_replayable);

    // Lowest-index empty entry takes the new load.
    always_comb begin
        o_alloc_en  = '0;
        alloc_found = 1'b0;
        if (alloc_fire) begin
            for (int i = 0; i < OPTN_LQ_DEPTH; i++) begin
                if (!alloc_found && i_entry_empty[i]) begin
                    o_alloc_en[i] = 1'b1;
                    alloc_found   = 1'b1;
                end
            end
        end
    end

    // Round-robin search starting at the pointer; index arithmetic wraps naturally.
    always_comb begin
        winner       = rr_ptr;
        replay_found = 1'b0;
        probe        = rr_ptr;
        for (int i = 0; i < OPTN_LQ_DEPTH; i++) begin
            probe = rr_ptr + LQ_IDX_WIDTH'(i);
            if (!replay_found && i_entry_replayable[probe]) begin
                winner       = probe;
                replay_found = 1'b1;
            end
        end
    end

    always_comb begin
        o_entry_replay_en = '0;
        if (replay_fire) begin
            o_entry_replay_en[winner] = 1'b1;
        end
    end

    always_comb begin
        count_next = count + CW'(|o_alloc_en) - CW'(|i_entry_retire_ack);
        if (i_flush) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            o_full <= 1'b0;
        end else begin
            count  <= count_next;
            o_full <= (count_next == CW'(OPTN_LQ_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_replay_valid <= 1'b0;
            rr_ptr         <= '0;
            o_replay_op    <= '0;
            o_replay_tag   <= '0;
            o_replay_addr  <= '0;
        end else if (i_flush) begin
            o_replay_valid <= 1'b0;
            rr_ptr         <= '0;
        end else if (stage_load) begin
            if (replay_fire) begin
                o_replay_valid <= 1'b1;
                rr_ptr         <= winner + LQ_IDX_WIDTH'(1);
                o_replay_op    <= i_entry_replay_op[winner*OPW +: OPW];
                o_replay_tag   <= i_entry_replay_tag[winner*OPTN_ROB_IDX_WIDTH +: OPTN_ROB_IDX_WIDTH];
                o_replay_addr  <= i_entry_replay_addr[winner*OPTN_ADDR_WIDTH +: OPTN_ADDR_WIDTH];
            end else begin
                o_replay_valid <= 1'b0;
            end
        end
    end

    assign o_rob_retire_ack           = |i_entry_retire_ack;
    assign o_rob_retire_misspeculated = |(i_entry_retire_ack & i_entry_retire_misspec);

endmodule

// File: tb/tb_procyon_lsu_lq_ctrl.sv
// Directed bench for procyon_lsu_lq_ctrl: a vector table for allocation/retire
// behaviour plus hand-written sequences for fill, replay arbitration, stall and flush.
`ifndef PCYN_OP_WIDTH
`define PCYN_OP_WIDTH 5
`endif

module tb_procyon_lsu_lq_ctrl;

    localparam int AW  = 32;
    localparam int TW  = 5;
    localparam int D   = 8;
    localparam int OPW = `PCYN_OP_WIDTH;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [D-1:0]     entry_empty;
    logic [D-1:0]     entry_replayable;
    logic [D*OPW-1:0] entry_op;
    logic [D*TW-1:0]  entry_tag;
    logic [D*AW-1:0]  entry_addr;
    logic             alloc_req;
    logic [D-1:0]     alloc_en;
    logic             full;
    logic [D-1:0]     replay_en;
    logic             replay_valid;
    logic [OPW-1:0]   replay_op;
    logic [TW-1:0]    replay_tag;
    logic [AW-1:0]    replay_addr;
    logic             replay_ack;
    logic [D-1:0]     retire_ack;
    logic [D-1:0]     retire_misspec;
    logic             rob_ack;
    logic             rob_misspec;

    int n_cmp;
    int n_err;

    procyon_lsu_lq_ctrl #(
        .OPTN_ADDR_WIDTH(AW),
        .OPTN_ROB_IDX_WIDTH(TW),
        .OPTN_LQ_DEPTH(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_flush(flush),
        .i_entry_empty(entry_empty),
        .i_entry_replayable(entry_replayable),
        .i_entry_replay_op(entry_op),
        .i_entry_replay_tag(entry_tag),
        .i_entry_replay_addr(entry_addr),
        .i_alloc_req(alloc_req),
        .o_alloc_en(alloc_en),
        .o_full(full),
        .o_entry_replay_en(replay_en),
        .o_replay_valid(replay_valid),
        .o_replay_op(replay_op),
        .o_replay_tag(replay_tag),
        .o_replay_addr(replay_addr),
        .i_replay_ack(replay_ack),
        .i_entry_retire_ack(retire_ack),
        .i_entry_retire_misspec(retire_misspec),
        .o_rob_retire_ack(rob_ack),
        .o_rob_retire_misspeculated(rob_misspec)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [D-1:0] empty;
        logic         req;
        logic         flush;
        logic [D-1:0] ret;
        logic [D-1:0] ms;
        logic [D-1:0] exp_alloc;
        logic         exp_ack;
        logic         exp_ms;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge, outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush            = 1'b0;
        alloc_req        = 1'b0;
        entry_empty      = '0;
        entry_replayable = '0;
        replay_ack       = 1'b0;
        retire_ack       = '0;
        retire_misspec   = '0;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        alloc_req        = 1'b1;
        entry_empty      = 8'hFF;
        entry_replayable = 8'hFF;
        replay_ack       = 1'b1;
        step();
        #1;
        check("rst_alloc_en", 64'(alloc_en), 64'h0);
        check("rst_replay_en", 64'(replay_en), 64'h0);
        step();
        idle_inputs();
        rst = 1'b0;
        #1;
        check("rst_valid", 64'(replay_valid), 64'h0);
        check("rst_full", 64'(full), 64'h0);
        check("rst_tag", 64'(replay_tag), 64'h0);
        check("rst_addr", 64'(replay_addr), 64'h0);
        check("rst_op", 64'(replay_op), 64'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        idle_inputs();
        for (int i = 0; i < D; i++) begin
            entry_op[i*OPW +: OPW]  = OPW'(i + 3);
            entry_tag[i*TW +: TW]   = TW'(i + 1);
            entry_addr[i*AW +: AW]  = 32'hA000_0000 + 32'(i * 16);
        end

        // empty, req, flush, ret, ms, exp_alloc, exp_ack, exp_ms
        vecs[0] = '{8'hFF, 1'b1, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0};
        vecs[1] = '{8'hF0, 1'b1, 1'b0, 8'h08, 8'h08, 8'h10, 1'b1, 1'b1};
        vecs[2] = '{8'h80, 1'b1, 1'b0, 8'h08, 8'h04, 8'h80, 1'b1, 1'b0};
        vecs[3] = '{8'h06, 1'b0, 1'b0, 8'h01, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h24, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h04, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 8'h02, 8'h02, 8'h00, 1'b1, 1'b1};

        do_reset();

        // Table: allocation priority, retire reduction, flush suppressing allocation
        for (int v = 0; v < 7; v++) begin
            entry_empty    = vecs[v].empty;
            alloc_req      = vecs[v].req;
            flush          = vecs[v].flush;
            retire_ack     = vecs[v].ret;
            retire_misspec = vecs[v].ms;
            #1;
            check($sformatf("vec%0d_alloc_en", v), 64'(alloc_en), 64'(vecs[v].exp_alloc));
            check($sformatf("vec%0d_rob_ack", v), 64'(rob_ack), 64'(vecs[v].exp_ack));
            check($sformatf("vec%0d_rob_ms", v), 64'(rob_misspec), 64'(vecs[v].exp_ms));
            step();
            check($sformatf("vec%0d_full", v), 64'(full), 64'h0);
        end
        idle_inputs();

        // Fill all eight entries, lowest empty first
        do_reset();
        entry_empty = 8'hFF;
        alloc_req   = 1'b1;
        for (int i = 0; i < D; i++) begin
            #1;
            check($sformatf("fill%0d_alloc_en", i), 64'(alloc_en), 64'(8'h01 << i));
            if (i < D - 1) check($sformatf("fill%0d_not_full", i), 64'(full), 64'h0);
            step();
            entry_empty[i] = 1'b0;
        end
        check("fill_full", 64'(full), 64'h1);

        // Full: request blocked even with empties visible, retire in same cycle
        entry_empty = 8'hFF;
        retire_ack  = 8'h04;
        #1;
        check("full_alloc_blocked", 64'(alloc_en), 64'h0);
        check("full_retire_ack", 64'(rob_ack), 64'h1);
        step();
        alloc_req = 1'b0;
        step();
        check("after_retire_not_full", 64'(full), 64'h0);
        idle_inputs();

        // Round-robin replay among entries 0 and 4
        do_reset();
        entry_replayable = 8'h11;
        replay_ack       = 1'b1;
        #1;
        check("rr0_en", 64'(replay_en), 64'h01);
        step();
        check("rr0_valid", 64'(replay_valid), 64'h1);
        check("rr0_tag", 64'(replay_tag), 64'h1);
        check("rr0_addr", 64'(replay_addr), 64'hA000_0000);
        check("rr0_op", 64'(replay_op), 64'h3);
        check("rr1_en", 64'(replay_en), 64'h10);
        step();
        check("rr1_tag", 64'(replay_tag), 64'h5);
        check("rr1_addr", 64'(replay_addr), 64'hA000_0040);
        check("rr2_en", 64'(replay_en), 64'h01);
        step();
        check("rr2_tag", 64'(replay_tag), 64'h1);

        // Stall: stage holds entry 0 while entry 1 waits
        replay_ack       = 1'b0;
        entry_replayable = 8'h02;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d_en", c), 64'(replay_en), 64'h0);
            step();
            check($sformatf("stall%0d_valid", c), 64'(replay_valid), 64'h1);
            check($sformatf("stall%0d_tag", c), 64'(replay_tag), 64'h1);
        end
        replay_ack = 1'b1;
        #1;
        check("stall_release_en", 64'(replay_en), 64'h02);
        step();
        check("stall_release_tag", 64'(replay_tag), 64'h2);
        check("stall_release_valid", 64'(replay_valid), 64'h1);

        // No candidate while acked: stage drains, pointer holds at 2
        entry_replayable = 8'h00;
        step();
        check("drain_valid", 64'(replay_valid), 64'h0);
        entry_replayable = 8'h09;
        #1;
        check("ptr_hold_en", 64'(replay_en), 64'h08);
        step();

        // Flush with valid stage, allocation request and every entry replayable
        replay_ack       = 1'b0;
        entry_replayable = 8'hFF;
        entry_empty      = 8'hFF;
        alloc_req        = 1'b1;
        flush            = 1'b1;
        retire_ack       = 8'h01;
        retire_misspec   = 8'h01;
        #1;
        check("flush_alloc_en", 64'(alloc_en), 64'h0);
        check("flush_replay_en", 64'(replay_en), 64'h0);
        check("flush_rob_ms", 64'(rob_misspec), 64'h1);
        step();
        flush      = 1'b0;
        alloc_req  = 1'b0;
        retire_ack = '0;
        check("flush_valid", 64'(replay_valid), 64'h0);
        check("flush_full", 64'(full), 64'h0);
        #1;
        check("flush_ptr_zero_en", 64'(replay_en), 64'h01);
        step();

        // Reset while a replay is staged
        check("pre_rst_valid", 64'(replay_valid), 64'h1);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
